// File: rtl/lsu_pkg.sv
// Shared types for the LSU memory-access stage: size codes, FSM states and
// the captured-op record.
package lsu_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_RESP = 2'd2,
    ST_DONE      = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic        is_nop;
    logic        is_load;
    logic        is_store;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        zero_ext;
  } lsu_op_t;

  // Size 11 is never legal; a zero-extended word has no meaning on RV32.
  function automatic logic op_faults(input logic [1:0] size, input logic [1:0] off,
                                     input logic zero_ext);
    return (size == 2'b11) ||
           (size == SZ_H && off[0]) ||
           (size == SZ_W && off != 2'b00) ||
           (zero_ext && size == SZ_W);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store byte enables and replicated store data, plus the
// right-shift that brings the addressed byte of a read word down to bit 0.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] rdata_shifted
);

  logic [NUM_LANES-1:0][LANE_W-1:0] lanes;

  // Lane i carries store byte (i mod access width), giving the replication.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lanes[i] = (size == SZ_B) ? wdata[7:0] :
                      (size == SZ_H) ? wdata[(i % 2)*LANE_W +: LANE_W] :
                                       wdata[i*LANE_W +: LANE_W];
  end

  assign lane_wdata = lanes;

  always_comb begin
    be = 4'b1111;
    case (size)
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
  end

  assign rdata_shifted = rdata >> {off, 3'b000};

endmodule

// File: rtl/lsu_mem_access.sv
// LSU memory-access stage: one op in flight, alignment check, req/gnt/rvalid
// data port, lane-shifted load data handed to writeback.
module lsu_mem_access
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_nop,
  input  logic        in_is_load,
  input  logic        in_is_store,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [1:0]  in_size,
  input  logic        in_zero_ext,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_is_nop,
  output logic        out_is_load,
  output logic [31:0] out_data,
  output logic [1:0]  out_size,
  output logic        out_zero_ext,
  output logic        out_misalign
);

  lsu_state_e  state;
  lsu_op_t     op;
  logic        misalign;
  logic [31:0] data;

  logic [3:0]  be;
  logic [31:0] lane_wdata;
  logic [31:0] rdata_shifted;
  logic        no_access;
  logic        fault;

  assign no_access = in_is_nop || !(in_is_load || in_is_store);
  assign fault     = op_faults(in_size, in_addr[1:0], in_zero_ext);

  // Steering works from the captured op so the memory port is stable in REQ.
  lsu_lane_align u_align (
    .off           (op.addr[1:0]),
    .size          (op.size),
    .wdata         (op.wdata),
    .rdata         (mem_rdata),
    .be            (be),
    .lane_wdata    (lane_wdata),
    .rdata_shifted (rdata_shifted)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      op       <= '0;
      misalign <= 1'b0;
      data     <= '0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          op       <= '{is_nop: in_is_nop, is_load: in_is_load, is_store: in_is_store,
                        addr: in_addr, wdata: in_wdata, size: in_size,
                        zero_ext: in_zero_ext};
          misalign <= 1'b0;
          data     <= '0;
          if (no_access) begin
            state <= ST_DONE;
          end else if (fault) begin
            misalign <= 1'b1;
            state    <= ST_DONE;
          end else begin
            state <= ST_REQ;
          end
        end
        ST_REQ: if (mem_gnt) state <= op.is_load ? ST_WAIT_RESP : ST_DONE;
        ST_WAIT_RESP: if (mem_rvalid) begin
          data  <= rdata_shifted;
          state <= ST_DONE;
        end
        ST_DONE: if (out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Load wins when both class bits are set.
  assign in_ready     = (state == ST_IDLE);
  assign mem_req      = (state == ST_REQ);
  assign mem_we       = mem_req && op.is_store && !op.is_load;
  assign mem_addr     = {op.addr[31:2], 2'b00};
  assign mem_be       = mem_req ? be : 4'b0000;
  assign mem_wdata    = lane_wdata;

  assign out_valid    = (state == ST_DONE);
  assign out_is_nop   = op.is_nop;
  assign out_is_load  = op.is_load;
  assign out_data     = data;
  assign out_size     = op.size;
  assign out_zero_ext = op.zero_ext;
  assign out_misalign = misalign;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Scoreboard bench for lsu_mem_access: directed test-plan ops plus random ops,
// a memory responder that checks the request port, and an output monitor.
module tb_lsu_mem_access;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic        in_is_nop = 1'b0, in_is_load = 1'b0, in_is_store = 1'b0;
  logic [31:0] in_addr = '0, in_wdata = '0;
  logic [1:0]  in_size = '0;
  logic        in_zero_ext = 1'b0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        out_valid, out_ready = 1'b1;
  logic        out_is_nop, out_is_load, out_zero_ext, out_misalign;
  logic [31:0] out_data;
  logic [1:0]  out_size;

  lsu_mem_access dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_is_nop(in_is_nop), .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_size(in_size), .in_zero_ext(in_zero_ext),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_is_nop(out_is_nop), .out_is_load(out_is_load), .out_data(out_data),
    .out_size(out_size), .out_zero_ext(out_zero_ext), .out_misalign(out_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          nop, ld, mis, zext;
    logic [1:0]  size;
    logic [31:0] data;
    int          acc, lat;
  } exp_t;

  typedef struct {
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;
    bit          we, ld;
    int          gdly, rdly;
  } mexp_t;

  exp_t  oq[$];
  mexp_t mq[$];
  int    checks = 0, failures = 0;
  int    cyc = 0;
  bit    force_low = 1'b0, rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_msg(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference model: derive the expected memory transaction and result from
  // the op fields, then drive the op for one accepting cycle.
  task automatic issue(input bit nop, ld, st, input logic [31:0] addr, wdata,
                       input logic [1:0] size, input bit zext, input logic [31:0] rdata,
                       input int gdly, rdly, lat, input bit abandon);
    exp_t  e;
    mexp_t m;
    bit    access, fault, ok;
    int    n;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) begin fail_msg("in_ready_timeout"); return; end
    access = !nop && (ld || st);
    fault  = access && (size == 2'b11 || (size == 2'b01 && addr[0]) ||
                        (size == 2'b10 && addr[1:0] != 2'b00) || (zext && size == 2'b10));
    e.nop = nop; e.ld = ld; e.size = size; e.zext = zext; e.mis = fault;
    e.data = '0; e.acc = cyc + 1; e.lat = lat;
    if (access && !fault) begin
      n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
      m.addr = addr & 32'hFFFF_FFFC;
      m.ld = ld; m.we = !ld; m.gdly = gdly; m.rdly = rdly; m.rdata = rdata;
      m.be = '0;
      m.wdata = '0;
      for (int b = 0; b < 4; b++) begin
        if (b >= int'(addr[1:0]) && b < int'(addr[1:0]) + n) m.be[b] = 1'b1;
        m.wdata[8*b +: 8] = wdata[8*(b % n) +: 8];
      end
      if (ld) e.data = rdata >> (8 * int'(addr[1:0]));
      mq.push_back(m);
    end
    if (!abandon) oq.push_back(e);
    in_valid = 1'b1; in_is_nop = nop; in_is_load = ld; in_is_store = st;
    in_addr = addr; in_wdata = wdata; in_size = size; in_zero_ext = zext;
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_addr = $urandom(); in_wdata = $urandom();
  endtask

  // Memory responder: checks every request cycle against the model (so held
  // values are checked each cycle) and answers with the planned delays.
  initial begin
    int wcnt;
    mexp_t m;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        if (mq.size() == 0) begin
          fail_msg("unexpected_mem_req");
        end else begin
          m = mq[0];
          chk("mem_addr", mem_addr, m.addr);
          chk("mem_we", {31'd0, mem_we}, {31'd0, m.we});
          chk("mem_be", {28'd0, mem_be}, {28'd0, m.be});
          if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
          if (wcnt == m.gdly) begin
            void'(mq.pop_front());
            wcnt = 0;
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0;
            if (m.ld) begin
              repeat (m.rdly) @(negedge clk);
              mem_rvalid = 1'b1; mem_rdata = m.rdata;
              @(negedge clk);
              mem_rvalid = 1'b0; mem_rdata = $urandom();
            end
          end else begin
            wcnt++;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = force_low ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Output monitor: compares every DONE cycle against the head of the queue.
  initial begin
    exp_t e;
    bit seen, chk_idle;
    seen = 1'b0; chk_idle = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_idle) begin
        chk("idle_after_done", {31'd0, in_ready}, 32'd1);
        chk_idle = 1'b0;
      end
      if (rst_n === 1'b1 && out_valid === 1'b1) begin
        if (oq.size() == 0) begin
          fail_msg("unexpected_out_valid");
        end else begin
          e = oq[0];
          if (!seen && e.lat >= 0) chk("latency", cyc - e.acc + 1, e.lat);
          seen = 1'b1;
          chk("out_is_nop", {31'd0, out_is_nop}, {31'd0, e.nop});
          chk("out_is_load", {31'd0, out_is_load}, {31'd0, e.ld});
          chk("out_size", {30'd0, out_size}, {30'd0, e.size});
          chk("out_zero_ext", {31'd0, out_zero_ext}, {31'd0, e.zext});
          chk("out_misalign", {31'd0, out_misalign}, {31'd0, e.mis});
          chk("out_data", out_data, e.data);
          chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
          if (out_ready) begin
            void'(oq.pop_front());
            seen = 1'b0;
            chk_idle = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    bit ok;
    int cls;
    bit nop, ld, st, zx;
    logic [31:0] a, w;
    logic [1:0] sz;
    int szr;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset.mem_req", {31'd0, mem_req}, 32'd0);
    chk("reset.mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset.mem_be", {28'd0, mem_be}, 32'd0);
    chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset.out_misalign", {31'd0, out_misalign}, 32'd0);
    chk("reset.out_data", out_data, 32'd0);

    // Directed cases, best-case handshakes unless noted.
    issue(0, 1, 0, 32'h0000_1003, 32'h0, 2'b00, 0, 32'h80FF_0000, 0, 0, 3, 0);
    issue(0, 0, 1, 32'h0000_2002, 32'hDEAD_BEEF, 2'b01, 0, 32'h0, 4, 0, -1, 0);
    issue(0, 0, 1, 32'h0000_5001, 32'h0000_00A5, 2'b00, 0, 32'h0, 0, 0, 2, 0);
    issue(0, 1, 0, 32'h0000_3001, 32'h0, 2'b10, 0, 32'h0, 0, 0, 1, 0);
    issue(0, 1, 0, 32'h0000_3001, 32'h0, 2'b01, 1, 32'h0, 0, 0, 1, 0);
    issue(0, 1, 0, 32'h0000_3000, 32'h0, 2'b10, 1, 32'h0, 0, 0, 1, 0);
    issue(1, 0, 0, 32'h0000_6000, 32'h1234, 2'b10, 0, 32'h0, 0, 0, 1, 0);
    issue(0, 1, 1, 32'h0000_7002, 32'hFFFF, 2'b01, 1, 32'hC001_D00D, 0, 0, 3, 0);

    // Reset while waiting for read data; the late rvalid must be ignored.
    issue(0, 1, 0, 32'h0000_8000, 32'h0, 2'b10, 0, 32'hAAAA_5555, 0, 4, -1, 1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("abandon.out_valid", {31'd0, out_valid}, 32'd0);
      chk("abandon.in_ready", {31'd0, in_ready}, 32'd1);
    end

    // Writeback stall: result held while out_ready is low.
    force_low = 1'b1;
    out_ready = 1'b0;
    issue(0, 1, 0, 32'h0000_4000, 32'h0, 2'b10, 0, 32'h1234_5678, 0, 0, 3, 0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) fail_msg("stall.out_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      chk("stall.out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall.out_data", out_data, 32'h1234_5678);
      chk("stall.in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    force_low = 1'b0;

    // Random ops with random memory delays and writeback back-pressure.
    rand_ready = 1'b1;
    for (int k = 0; k < 150; k++) begin
      cls = $urandom_range(0, 19);
      nop = (cls < 2);
      ld  = (cls == 3) || (cls >= 4 && cls < 12) || (nop && $urandom_range(0, 1) == 1);
      st  = (cls == 3) || (cls >= 12);
      szr = $urandom_range(0, 9);
      sz  = (szr < 3) ? 2'b00 : (szr < 6) ? 2'b01 : (szr < 9) ? 2'b10 : 2'b11;
      zx  = ($urandom_range(0, 3) == 0);
      a   = $urandom();
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      w   = $urandom();
      issue(nop, ld, st, a, w, sz, zx, $urandom(), $urandom_range(0, 3),
            $urandom_range(0, 3), -1, 0);
    end

    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (oq.size() == 0 && mq.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) fail_msg("drain_timeout");
    repeat (6) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
